// File: rtl/sonic_rx_prg_decode.sv
// ---------------------------------------------------------------------------
// sonic_rx_prg_decode
//
// Receive-side PCIe target decoder for the SoNIC command path. It takes host
// Memory Write TLPs from the PCIe backend receive port (128-bit descriptor /
// data interface) and turns every payload DWORD into one single-cycle
// program-register write for the command register file and command
// controller. Non-write TLPs, oversize writes and, when BAR checking is
// compiled in, writes that miss the decoded BAR are consumed and counted.
//
// Compile-time option:
//   SONIC_RX_PRG_BAR_CHECK_EN  when defined, an MWr is decoded only if
//                              rx_bar[BAR_NUM] is set; otherwise it is
//                              discarded and counted. When undefined, rx_bar
//                              is ignored.
//
// Parameters:
//   MAX_DW      largest accepted payload in DWORDs (longer MWr is dropped)
//   BAR_NUM     BAR index checked when BAR checking is compiled in
//
// Ports:
//   clk_in      clock
//   rstn        asynchronous active-low reset
//   rx_req      descriptor valid, held until rx_ack
//   rx_desc     TLP header, DW0 in [127:96] .. DW3 in [31:0]
//   rx_bar      BAR-hit vector, valid with rx_req
//   rx_ack      one-cycle descriptor accept
//   rx_dfr      more data beats follow (not needed: beats follow length)
//   rx_dv       data beat valid
//   rx_data     payload beat, DW lane k in [32k+31:32k]
//   rx_ws       wait-state; a beat transfers when rx_dv=1 and rx_ws=0
//   rx_abort    always 0
//   prg_wrena   register-write strobe, one cycle per written DWORD
//   prg_wrdata  register-write data
//   prg_addr    register DWORD address
//   drop_cnt    saturating count of discarded TLPs
// ---------------------------------------------------------------------------
module sonic_rx_prg_decode #(
  parameter int MAX_DW  = 16,
  parameter int BAR_NUM = 0
) (
  input  logic         clk_in,
  input  logic         rstn,
  input  logic         rx_req,
  input  logic [127:0] rx_desc,
  input  logic [7:0]   rx_bar,
  output logic         rx_ack,
  input  logic         rx_dfr,
  input  logic         rx_dv,
  input  logic [127:0] rx_data,
  output logic         rx_ws,
  output logic         rx_abort,
  output logic         prg_wrena,
  output logic [31:0]  prg_wrdata,
  output logic [7:0]   prg_addr,
  output logic [15:0]  drop_cnt
);

  localparam logic [10:0] MAX_DW_L = 11'(MAX_DW);
  localparam logic [2:0]  BAR_IDX  = 3'(BAR_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_DATA,
    S_DRAIN,
    S_DISCARD
  } state_t;

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_t      state_q;
  logic        rx_ack_q;
  logic        rx_ws_q;
  logic        prg_wrena_q;
  logic [31:0] prg_wrdata_q;
  logic [7:0]  prg_addr_q;
  logic [15:0] drop_cnt_q;
  logic [127:0] buf_q;       // one-beat payload buffer
  logic [1:0]  lane_q;       // next DW lane to emit / first lane of next beat
  logic [10:0] rem_q;        // DWORDs of the current TLP still to go
  logic [7:0]  addr_q;       // register address of the next DWORD
  logic        first_q;      // next DWORD is DW0 of the TLP
  logic [3:0]  first_be_q;
  logic [3:0]  last_be_q;

  // -------------------------------------------------------------------------
  // Header decode (the descriptor is stable while rx_req is held)
  // -------------------------------------------------------------------------
  logic [1:0]  hdr_fmt_d;
  logic [4:0]  hdr_type_d;
  logic [10:0] hdr_len_d;
  logic [31:0] hdr_addr_d;
  logic        hdr_has_data_d;
  logic        hdr_is_mwr_d;
  logic        bar_hit_d;
  logic        hdr_bar_ok_d;
  logic        hdr_accept_d;

  always_comb begin
    hdr_fmt_d      = rx_desc[126:125];
    hdr_type_d     = rx_desc[124:120];
    // A length field of zero encodes the maximum of 1024 DWORDs.
    hdr_len_d      = (rx_desc[105:96] == 10'd0) ? 11'd1024 : {1'b0, rx_desc[105:96]};
    // 4DW headers carry the low address in DW3, 3DW headers in DW2.
    hdr_addr_d     = hdr_fmt_d[0] ? rx_desc[31:0] : rx_desc[63:32];
    hdr_has_data_d = hdr_fmt_d[1];
    hdr_is_mwr_d   = hdr_has_data_d && (hdr_type_d == 5'd0);
    bar_hit_d      = rx_bar[BAR_IDX];
`ifdef SONIC_RX_PRG_BAR_CHECK_EN
    hdr_bar_ok_d   = bar_hit_d;
`else
    hdr_bar_ok_d   = 1'b1;
`endif
    hdr_accept_d   = hdr_is_mwr_d && (hdr_len_d <= MAX_DW_L) && hdr_bar_ok_d;
  end

  // -------------------------------------------------------------------------
  // Discard bookkeeping: a beat carries (4 - starting lane) DWORDs. In the
  // ACK cycle the counters are not loaded yet, so use the decoded header.
  // -------------------------------------------------------------------------
  logic [1:0]  dis_lane_d;
  logic [10:0] dis_rem_d;
  logic [10:0] dis_room_d;
  logic        dis_last_d;

  always_comb begin
    dis_lane_d = (state_q == S_ACK) ? hdr_addr_d[3:2] : lane_q;
    dis_rem_d  = (state_q == S_ACK) ? hdr_len_d : rem_q;
    dis_room_d = 11'd4 - {9'd0, dis_lane_d};
    dis_last_d = (dis_rem_d <= dis_room_d);
  end

  // -------------------------------------------------------------------------
  // Drain path: pick the buffered lane and its byte enable
  // -------------------------------------------------------------------------
  logic [31:0] buf_lane [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf_lane
      assign buf_lane[gi] = buf_q[32*gi +: 32];
    end
  endgenerate

  logic [31:0] buf_dw_d;
  logic [3:0]  dw_be_d;
  logic        dw_write_d;
  logic [15:0] drop_next_d;

  always_comb begin
    buf_dw_d = buf_lane[lane_q];
    // DW0 uses firstBE; the final DW of a multi-DW TLP uses lastBE.
    if (first_q) begin
      dw_be_d = first_be_q;
    end else if (rem_q == 11'd1) begin
      dw_be_d = last_be_q;
    end else begin
      dw_be_d = 4'hF;
    end
    // Registers are whole DWORDs: a partial enable skips the write.
    dw_write_d  = (dw_be_d == 4'hF);
    drop_next_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rx_ack_q     <= 1'b0;
      rx_ws_q      <= 1'b0;
      prg_wrena_q  <= 1'b0;
      prg_wrdata_q <= 32'd0;
      prg_addr_q   <= 8'd0;
      drop_cnt_q   <= 16'd0;
      buf_q        <= 128'd0;
      lane_q       <= 2'd0;
      rem_q        <= 11'd0;
      addr_q       <= 8'd0;
      first_q      <= 1'b0;
      first_be_q   <= 4'd0;
      last_be_q    <= 4'd0;
    end else begin
      rx_ack_q    <= 1'b0;
      prg_wrena_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rx_req) begin
            rx_ack_q <= 1'b1;
            state_q  <= S_ACK;
          end
        end

        S_ACK: begin
          lane_q     <= hdr_addr_d[3:2];
          rem_q      <= hdr_len_d;
          addr_q     <= hdr_addr_d[9:2];
          first_q    <= 1'b1;
          first_be_q <= rx_desc[67:64];
          last_be_q  <= rx_desc[71:68];
          if (hdr_accept_d) begin
            // A backend that presents the first beat together with the
            // accept is served directly rather than losing the beat.
            if (rx_dv) begin
              buf_q   <= rx_data;
              rx_ws_q <= 1'b1;
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            drop_cnt_q <= drop_next_d;
            if (!hdr_has_data_d) begin
              state_q <= S_IDLE;
            end else if (rx_dv) begin
              if (dis_last_d) begin
                state_q <= S_IDLE;
              end else begin
                rem_q   <= dis_rem_d - dis_room_d;
                lane_q  <= 2'd0;
                state_q <= S_DISCARD;
              end
            end else begin
              state_q <= S_DISCARD;
            end
          end
        end

        S_DATA: begin
          if (rx_dv) begin
            buf_q   <= rx_data;
            rx_ws_q <= 1'b1;
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          prg_wrena_q <= dw_write_d;
          if (dw_write_d) begin
            prg_wrdata_q <= buf_dw_d;
            prg_addr_q   <= addr_q;
          end
          // Address advances even for skipped DWORDs and wraps at 8 bits.
          addr_q  <= addr_q + 8'd1;
          rem_q   <= rem_q - 11'd1;
          lane_q  <= lane_q + 2'd1;
          first_q <= 1'b0;
          if (rem_q == 11'd1) begin
            rx_ws_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (lane_q == 2'd3) begin
            rx_ws_q <= 1'b0;
            state_q <= S_DATA;
          end
        end

        S_DISCARD: begin
          if (rx_dv) begin
            if (dis_last_d) begin
              state_q <= S_IDLE;
            end else begin
              rem_q  <= dis_rem_d - dis_room_d;
              lane_q <= 2'd0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_ack     = rx_ack_q;
  assign rx_ws      = rx_ws_q;
  assign rx_abort   = 1'b0;
  assign prg_wrena  = prg_wrena_q;
  assign prg_wrdata = prg_wrdata_q;
  assign prg_addr   = prg_addr_q;
  assign drop_cnt   = drop_cnt_q;

  // Inputs and decode bits that carry no information for this block.
  logic unused_ok;
  assign unused_ok = ^{rx_dfr, rx_desc, rx_bar, hdr_addr_d, bar_hit_d};

endmodule

// File: tb/tb_sonic_rx_prg_decode.sv
module tb_sonic_rx_prg_decode;

  logic         clk_in = 1'b0;
  logic         rstn = 1'b0;
  logic         rx_req = 1'b0;
  logic [127:0] rx_desc = '0;
  logic [7:0]   rx_bar = '0;
  logic         rx_ack;
  logic         rx_dfr = 1'b0;
  logic         rx_dv = 1'b0;
  logic [127:0] rx_data = '0;
  logic         rx_ws;
  logic         rx_abort;
  logic         prg_wrena;
  logic [31:0]  prg_wrdata;
  logic [7:0]   prg_addr;
  logic [15:0]  drop_cnt;

  always #5 clk_in = ~clk_in;

  sonic_rx_prg_decode #(.MAX_DW(16), .BAR_NUM(0)) dut (
    .clk_in     (clk_in),
    .rstn       (rstn),
    .rx_req     (rx_req),
    .rx_desc    (rx_desc),
    .rx_bar     (rx_bar),
    .rx_ack     (rx_ack),
    .rx_dfr     (rx_dfr),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .rx_ws      (rx_ws),
    .rx_abort   (rx_abort),
    .prg_wrena  (prg_wrena),
    .prg_wrdata (prg_wrdata),
    .prg_addr   (prg_addr),
    .drop_cnt   (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Write log captured away from the active edge.
  int          cyc = 0;
  int          wn  = 0;
  logic [7:0]  wa   [64];
  logic [31:0] wd   [64];
  logic        wws  [64];
  int          wcyc [64];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (prg_wrena && wn < 64) begin
      wa[wn]   <= prg_addr;
      wd[wn]   <= prg_wrdata;
      wws[wn]  <= rx_ws;
      wcyc[wn] <= cyc;
      wn       <= wn + 1;
      $display("write: addr=0x%02h data=0x%08h ws=%0b cycle=%0d", prg_addr, prg_wrdata, rx_ws, cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_desc(input logic [1:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len, input logic [3:0] lbe,
                                           input logic [3:0] fbe, input logic [31:0] addr);
    logic [127:0] d;
    d = '0;
    d[126:125] = fmt;
    d[124:120] = typ;
    d[105:96]  = len;
    d[71:68]   = lbe;
    d[67:64]   = fbe;
    if (fmt[0]) d[31:0] = addr;
    else        d[63:32] = addr;
    return d;
  endfunction

  // Present a header, expect rx_ack exactly one cycle later for one cycle.
  task automatic send_hdr(input logic [127:0] d, input logic [7:0] bar, input string tag);
    int n;
    n = 0;
    @(negedge clk_in);
    rx_desc = d;
    rx_bar  = bar;
    rx_req  = 1'b1;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (!rx_ack && n < 20);
    check({tag, "_ack_latency"}, n, 1);
    @(posedge clk_in);
    #1;
    rx_req = 1'b0;
    check({tag, "_ack_pulse"}, {31'd0, rx_ack}, 0);
    $display("hdr %s: ack after %0d cycle(s)", tag, n);
  endtask

  // Present one data beat and hold it until it transfers (rx_ws low at edge).
  task automatic send_beat(input logic [127:0] d, input string tag);
    int   n;
    logic ws_s;
    n = 0;
    ws_s = 1'b1;
    rx_data = d;
    rx_dv   = 1'b1;
    do begin
      @(negedge clk_in);
      ws_s = rx_ws;
      @(posedge clk_in);
      #1;
      n++;
    end while (ws_s && n < 50);
    rx_dv = 1'b0;
    check({tag, "_beat_taken"}, {31'd0, ws_s}, 0);
    $display("beat %s: taken after %0d cycle(s)", tag, n);
  endtask

  int   base;
  int   k;
  logic seen;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_ack",    {31'd0, rx_ack}, 0);
    check("rst_ws",     {31'd0, rx_ws}, 0);
    check("rst_abort",  {31'd0, rx_abort}, 0);
    check("rst_wrena",  {31'd0, prg_wrena}, 0);
    check("rst_wrdata", prg_wrdata, 0);
    check("rst_addr",   {24'd0, prg_addr}, 0);
    check("rst_drop",   {16'd0, drop_cnt}, 0);
    rstn = 1'b1;

    // ---------------- 3DW MWr, 1 DW at 0x10 ----------------
    base = wn;
    send_hdr(mk_desc(2'b10, 5'd0, 10'd1, 4'h0, 4'hF, 32'h0000_0010), 8'h01, "t1");
    send_beat({96'd0, 32'hDEAD_BEEF}, "t1");
    repeat (6) @(negedge clk_in);
    check("t1_count", wn - base, 1);
    check("t1_addr",  {24'd0, wa[base]}, 32'h04);
    check("t1_data",  wd[base], 32'hDEAD_BEEF);

    // ---------------- 4DW MWr, 4 DW at 0x08, two beats ----------------
    base = wn;
    send_hdr(mk_desc(2'b11, 5'd0, 10'd4, 4'hF, 4'hF, 32'h0000_0008), 8'h01, "t2");
    send_beat({32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000}, "t2a");
    send_beat({32'hBBBB_0013, 32'hAAAA_0012, 32'h5555_0011, 32'h4444_0010}, "t2b");
    repeat (6) @(negedge clk_in);
    check("t2_count", wn - base, 4);
    check("t2_addr0", {24'd0, wa[base]},   32'h02);
    check("t2_data0", wd[base],            32'h2222_0002);
    check("t2_addr1", {24'd0, wa[base+1]}, 32'h03);
    check("t2_data1", wd[base+1],          32'h3333_0003);
    check("t2_addr2", {24'd0, wa[base+2]}, 32'h04);
    check("t2_data2", wd[base+2],          32'h4444_0010);
    check("t2_addr3", {24'd0, wa[base+3]}, 32'h05);
    check("t2_data3", wd[base+3],          32'h5555_0011);
    check("t2_ws_beat1", {31'd0, wws[base]},   1);
    check("t2_ws_beat2", {31'd0, wws[base+2]}, 1);
    check("t2_gap_beat1", wcyc[base+1] - wcyc[base],   1);
    check("t2_gap_beat2", wcyc[base+3] - wcyc[base+2], 1);

    // ---------------- address wrap 0x3FC, 2 DW ----------------
    base = wn;
    send_hdr(mk_desc(2'b10, 5'd0, 10'd2, 4'hF, 4'hF, 32'h0000_03FC), 8'h01, "t3");
    send_beat({32'hCAFE_00FF, 96'd0}, "t3a");
    send_beat({96'd0, 32'hCAFE_0000}, "t3b");
    repeat (6) @(negedge clk_in);
    check("t3_count", wn - base, 2);
    check("t3_addr0", {24'd0, wa[base]},   32'hFF);
    check("t3_data0", wd[base],            32'hCAFE_00FF);
    check("t3_addr1", {24'd0, wa[base+1]}, 32'h00);
    check("t3_data1", wd[base+1],          32'hCAFE_0000);

    // ---------------- partial firstBE skips DW0 ----------------
    base = wn;
    send_hdr(mk_desc(2'b10, 5'd0, 10'd3, 4'hF, 4'h3, 32'h0000_0100), 8'h01, "t5");
    send_beat({32'h0, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, "t5");
    repeat (6) @(negedge clk_in);
    check("t5_count", wn - base, 2);
    check("t5_addr0", {24'd0, wa[base]},   32'h41);
    check("t5_data0", wd[base],            32'hA1A1_A1A1);
    check("t5_addr1", {24'd0, wa[base+1]}, 32'h42);
    check("t5_data1", wd[base+1],          32'hA2A2_A2A2);

    // ---------------- MRd then oversize MWr: both dropped ----------------
    base = wn;
    send_hdr(mk_desc(2'b00, 5'd0, 10'd1, 4'h0, 4'hF, 32'h0000_0200), 8'h01, "t4rd");
    send_hdr(mk_desc(2'b10, 5'd0, 10'd17, 4'hF, 4'hF, 32'h0000_0000), 8'h01, "t4big");
    for (int i = 0; i < 5; i++) begin
      send_beat({4{32'h0BAD_0000 + 32'(i)}}, "t4");
    end
    repeat (6) @(negedge clk_in);
    check("t4_count", wn - base, 0);
    check("t4_drop",  {16'd0, drop_cnt}, 2);

    // ---------------- reset mid-TLP, then a fresh 1-DW MWr ----------------
    send_hdr(mk_desc(2'b11, 5'd0, 10'd4, 4'hF, 4'hF, 32'h0000_0020), 8'h01, "t6");
    send_beat({32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, "t6");
    k = 0;
    seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk_in);
      seen = prg_wrena;
      k++;
    end
    check("t6_first_wr",   {31'd0, seen}, 1);
    check("t6_first_addr", {24'd0, prg_addr}, 32'h08);
    rstn = 1'b0;
    #1;
    check("t6_rst_wrena",  {31'd0, prg_wrena}, 0);
    check("t6_rst_wrdata", prg_wrdata, 0);
    check("t6_rst_addr",   {24'd0, prg_addr}, 0);
    check("t6_rst_ws",     {31'd0, rx_ws}, 0);
    check("t6_rst_drop",   {16'd0, drop_cnt}, 0);
    repeat (2) @(negedge clk_in);
    rstn = 1'b1;

    base = wn;
    send_hdr(mk_desc(2'b10, 5'd0, 10'd1, 4'h0, 4'hF, 32'h0000_0040), 8'h00, "t7");
    send_beat({96'd0, 32'h5A5A_1234}, "t7");
    repeat (6) @(negedge clk_in);
`ifdef SONIC_RX_PRG_BAR_CHECK_EN
    check("t7_count", wn - base, 0);
    check("t7_drop",  {16'd0, drop_cnt}, 1);
`else
    check("t7_count", wn - base, 1);
    check("t7_addr",  {24'd0, wa[base]}, 32'h10);
    check("t7_data",  wd[base], 32'h5A5A_1234);
    check("t7_drop",  {16'd0, drop_cnt}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sonic_rx_prg_decode.md
# sonic_rx_prg_decode

Receive-side PCIe target decoder for the SoNIC command path. It accepts host Memory Write TLPs from the PCIe backend receive port (descriptor/data, 128-bit Avalon-ST) and serialises each payload DWORD into one single-cycle program-register write (`prg_wrena/prg_wrdata/prg_addr`). That register-write interface feeds the command register file and the command controller that executes host commands. Non-write TLPs, oversize writes and (optionally) writes to other BARs are consumed and dropped.

## Interface
- `MAX_DW`, 16: largest accepted payload in DWORDs; longer MWr TLPs are discarded.
- `BAR_NUM`, 0: BAR index decoded when BAR checking is compiled in.
- `clk_in` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `rx_req` in 1: descriptor valid; held until `rx_ack`.
- `rx_desc` in 128: TLP header; `[127:96]`=DW0, `[95:64]`=DW1, `[63:32]`=DW2, `[31:0]`=DW3.
- `rx_bar` in 8: BAR-hit vector, valid with `rx_req`.
- `rx_ack` out 1: one-cycle descriptor accept.
- `rx_dfr` in 1: more data beats follow (informational; beat count is derived from length).
- `rx_dv` in 1: data beat valid.
- `rx_data` in 128: payload beat; DW lane k = bits `[32k+31:32k]`.
- `rx_ws` out 1: wait-state; a beat transfers only when `rx_dv=1 && rx_ws=0`.
- `rx_abort` out 1: tied 0.
- `prg_wrena` out 1: register-write strobe, one cycle per DWORD.
- `prg_wrdata` out 32: write data.
- `prg_addr` out 8: DWORD register address.
- `drop_cnt` out 16: count of discarded TLPs, saturating at 16'hFFFF.

## Operation
- Header decode: fmt=`desc[126:125]`, type=`desc[124:120]`, length=`desc[105:96]` (0 means 1024), lastBE=`desc[71:68]`, firstBE=`desc[67:64]`. 3DW MWr (fmt 2'b10, type 0): byte address=`desc[63:32]`. 4DW MWr (fmt 2'b11, type 0): byte address low=`desc[31:0]`.
- Start `prg_addr`=address`[9:2]`; first DW lane=address`[3:2]`; subsequent DWs ascend through lanes 0..3 of following beats.
- DW written only if its byte enable is 4'hF (firstBE for DW0, lastBE for final DW when length>1, all others implicit 4'hF); otherwise skipped, address still advances.
- `prg_addr` increments by 1 per DW and wraps 8'hFF→8'h00.
- Discard: non-MWr, length>`MAX_DW`, or BAR miss (when enabled). Data beats of discarded MWr are consumed (`rx_ws`=0); `drop_cnt` +1 at `rx_ack`.
- FSM: IDLE → (`rx_req`) ACK; ACK (assert `rx_ack`) → DATA if accepted, DISCARD if rejected with payload, IDLE if rejected header-only; DATA: capture beat into one-beat buffer → DRAIN; DRAIN: emit one DW/cycle, return to DATA when buffer empty and DWs remain, IDLE when remaining count reaches 0; DISCARD: count beats down to 0 → IDLE.

## Timing
- Reset values: `rx_ack`=0, `rx_ws`=0, `rx_abort`=0, `prg_wrena`=0, `prg_wrdata`=0, `prg_addr`=0, `drop_cnt`=0, FSM=IDLE, buffer empty.
- `rx_ack` pulses exactly one cycle, the cycle after `rx_req` is first sampled high in IDLE.
- `rx_ws` registered: high from the cycle after a beat is captured until the cycle after the buffer's last valid DW is emitted.
- Latency: captured beat → first `prg_wrena` 1 cycle; DWs on consecutive cycles, no bubbles within a beat.
- Outputs registered; `prg_wrena` high for exactly one cycle per written DW.
- New `rx_req` is not acknowledged before FSM returns to IDLE; back-to-back TLPs incur one IDLE cycle.
- `rstn` low mid-TLP: all state and outputs return to reset values asynchronously; the partial TLP is abandoned (backend reset by the same `rstn`).

## Configuration
- `SONIC_RX_PRG_BAR_CHECK_EN` defined: MWr decoded only when `rx_bar[BAR_NUM]`=1; else discarded and counted.
- Not defined: `rx_bar` ignored; every MWr within `MAX_DW` is decoded.

## Test plan
- 3DW MWr, address 0x0000_0010, length 1, firstBE 4'hF, data lane0=0xDEADBEEF → one `prg_wrena`, `prg_addr`=8'h04, `prg_wrdata`=0xDEADBEEF, `rx_ack` one cycle.
- 4DW MWr, address low 0x0000_0008, length 4, two beats → writes at 8'h02,03,04,05 from lanes 2,3 then 0,1; `rx_ws` high during drain; four consecutive writes.
- MWr, address 0x3FC, length 2 → writes at 8'hFF then 8'h00 (wrap).
- MRd header then MWr length 17 (`MAX_DW`=16) → no `prg_wrena`; all beats consumed; `drop_cnt`=2.
- MWr length 3, firstBE 4'h3, lastBE 4'hF → only second and third DW written, at start+1 and start+2.
- `rstn` asserted after first write of a 4-DW MWr → outputs zero immediately; after release, next 1-DW MWr decoded normally (with BAR check enabled, `rx_bar`=0 → dropped, `drop_cnt`=1).
